// File: rtl/dram_responder.sv
// DRAM stand-in on the responder side of the master FIFO protocol: in-order
// 128-bit line reads/writes from a small request queue, fixed read latency.
module dram_responder #(
  parameter int IDX_W        = 10,
  parameter int ADDR_LSB     = 3,
  parameter int READ_LATENCY = 4,
  parameter int REQ_DEPTH    = 4
) (
  input  logic         sys_clk,
  input  logic         RST,
  input  logic         req_en,
  input  logic         req_cmd,
  input  logic [26:0]  req_addr,
  input  logic [127:0] req_data,
  output logic         req_rdy,
  output logic         rsp_en,
  output logic [127:0] rsp_data,
  input  logic         rsp_rdy,
  output logic         busy
);

  // state  | meaning
  // IDLE   | pop queue head; writes retire here, reads capture data and leave
  // WAIT   | read latency countdown
  // RESP   | response presented until rsp_rdy
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam int         QA_W     = $clog2(REQ_DEPTH);
  localparam int         LINES    = 1 << IDX_W;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic           rsp_en_q;
  logic [127:0]   rsp_data_q;
  logic           busy_q;

  logic [QA_W:0]  wr_ptr_q, wr_ptr_d;
  logic [QA_W:0]  rd_ptr_q, rd_ptr_d;

  logic           q_cmd  [REQ_DEPTH];
  logic [IDX_W-1:0] q_idx [REQ_DEPTH];
  logic [127:0]   q_data [REQ_DEPTH];

  logic [127:0]   mem [LINES];

  logic             full, empty, push, pop;
  logic             head_cmd;
  logic [IDX_W-1:0] head_idx;
  logic [127:0]     head_data;
  logic [127:0]     head_line;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr;

  // Upper address bits alias onto the same line; only the index slice matters.
  assign req_idx     = req_addr[ADDR_LSB +: IDX_W];
  assign unused_addr = ^req_addr;

  assign full  = (wr_ptr_q[QA_W-1:0] == rd_ptr_q[QA_W-1:0]) &&
                 (wr_ptr_q[QA_W] != rd_ptr_q[QA_W]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push = req_en && !full;
  assign pop  = (state_q == S_IDLE) && !empty;

  assign head_cmd  = q_cmd [rd_ptr_q[QA_W-1:0]];
  assign head_idx  = q_idx [rd_ptr_q[QA_W-1:0]];
  assign head_data = q_data[rd_ptr_q[QA_W-1:0]];
  assign head_line = mem[head_idx];

  assign wr_ptr_d = wr_ptr_q + {{QA_W{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{QA_W{1'b0}}, pop};

  assign req_rdy  = !full;
  assign rsp_en   = rsp_en_q;
  assign rsp_data = rsp_data_q;
  assign busy     = busy_q;

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      busy_q   <= !empty || (state_q != S_IDLE);
    end
  end

  // Queue payload needs no reset: pointers alone define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      q_cmd [wr_ptr_q[QA_W-1:0]] <= req_cmd;
      q_idx [wr_ptr_q[QA_W-1:0]] <= req_idx;
      q_data[wr_ptr_q[QA_W-1:0]] <= req_data;
    end
  end

  // Line array survives RST so data written before a reset stays readable.
  always_ff @(posedge sys_clk) begin
    if (pop && !head_cmd) begin
      mem[head_idx] <= head_data;
    end
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rsp_en_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop && head_cmd) begin
            rsp_data_q <= head_line;
            cnt_q      <= LAT_LOAD;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= S_RESP;
            rsp_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_rdy) begin
            state_q  <= S_IDLE;
            rsp_en_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          rsp_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Randomised bench for dram_responder against an in-order line-memory model:
// every accepted write updates the model, every accepted read queues its expected data.
module tb_dram_responder;

  localparam int IDX_W    = 10;
  localparam int ADDR_LSB = 3;
  localparam int LAT      = 4;
  localparam int DEPTH    = 4;

  logic         sys_clk = 1'b0;
  logic         RST = 1'b1;
  logic         req_en = 1'b0;
  logic         req_cmd = 1'b0;
  logic [26:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic         rsp_rdy = 1'b1;
  logic         req_rdy, rsp_en, busy;
  logic [127:0] rsp_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rsp = 0;
  int n_pulses = 0;
  int n_reads_exp = 0;
  bit rsp_en_prev = 1'b0;

  logic [127:0] mem_m [int];
  logic [127:0] exp_q [$];
  int pool [8] = '{'h155, 'h2A0, 'h001, 'h3FF, 'h000, 'h0F0, 'h200, 'h10A};

  dram_responder #(
    .IDX_W(IDX_W), .ADDR_LSB(ADDR_LSB), .READ_LATENCY(LAT), .REQ_DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .RST(RST), .req_en(req_en), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .req_rdy(req_rdy),
    .rsp_en(rsp_en), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [26:0] a);
    return int'(a >> ADDR_LSB) % (1 << IDX_W);
  endfunction

  function automatic logic [26:0] mk_addr(input int idx);
    logic [26:0] a;
    a = 27'($urandom);
    a[ADDR_LSB +: IDX_W] = IDX_W'(idx);
    return a;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_accept(input bit cmd, input logic [26:0] a, input logic [127:0] d);
    if (cmd) begin
      exp_q.push_back(mem_m[idx_of(a)]);
      n_reads_exp++;
    end else begin
      mem_m[idx_of(a)] = d;
    end
  endtask

  // Response monitor: a response is consumed on the edge after a low-phase sample
  // showing rsp_en && rsp_rdy.
  always @(negedge sys_clk) begin
    if (!RST && rsp_en) begin
      if (!rsp_en_prev) n_pulses++;
      if (rsp_rdy) begin
        n_rsp++;
        if (exp_q.size() == 0) check_val("rsp_unexpected", 1, 0);
        else check_val("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
    rsp_en_prev = !RST && rsp_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send(input bit cmd, input logic [26:0] a, input logic [127:0] d);
    int waited = 0;
    req_en = 1'b1; req_cmd = cmd; req_addr = a; req_data = d;
    while (!req_rdy && waited < 200) begin
      @(posedge sys_clk); #1;
      waited++;
    end
    if (!req_rdy) begin
      check_val("send_timeout", 0, 1);
      req_en = 1'b0;
      return;
    end
    @(posedge sys_clk); #1;
    model_accept(cmd, a, d);
    req_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_en || exp_q.size() != 0) && n < 500) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check_val("idle_timeout", (n < 500), 1);
  endtask

  initial begin
    int t, n, base_rsp, base_pulses, saved_idx;
    logic [127:0] held, saved_val;
    bit pend, rdy_s, c, saw;
    logic [26:0] a;
    logic [127:0] d;

    repeat (3) @(posedge sys_clk);
    #1;
    check_val("reset_req_rdy", req_rdy, 1);
    check_val("reset_rsp_en", rsp_en, 0);
    check_val("reset_rsp_data", rsp_data, 0);
    check_val("reset_busy", busy, 0);
    RST = 1'b0;
    @(posedge sys_clk); #1;

    // Seed every line the bench will read; line 0x2A0 holds zero.
    foreach (pool[i]) send(1'b0, mk_addr(pool[i]), (pool[i] == 'h2A0) ? 128'd0 : rnd128());
    wait_idle();

    // Write then read, with latency measured from the read accept edge.
    send(1'b0, 27'h0000AA8, {4{32'h33333333}});
    wait_idle();
    base_rsp = n_rsp;
    send(1'b1, 27'h0000AA8, '0);
    t = cyc; n = 0;
    while (!rsp_en && n < 50) begin @(posedge sys_clk); #1; n++; end
    check_val("rd_latency", cyc - t, LAT + 1);
    check_val("wr_rd_data_now", rsp_data, {4{32'h33333333}});
    wait_idle();
    check_val("wr_rd_count", n_rsp - base_rsp, 1);

    // Read / write / read to one line back-to-back.
    base_pulses = n_pulses;
    send(1'b1, mk_addr('h2A0), '0);
    send(1'b0, mk_addr('h2A0), 128'hABCDEF00);
    send(1'b1, mk_addr('h2A0), '0);
    wait_idle();
    check_val("hazard_pulses", n_pulses - base_pulses, 2);

    // Backpressure: one read in RESP plus a full queue behind it.
    rsp_rdy = 1'b0;
    base_rsp = n_rsp;
    for (int i = 0; i < 5; i++) send(1'b1, mk_addr(pool[i]), '0);
    check_val("bp_req_rdy_low", req_rdy, 0);
    req_en = 1'b1; req_cmd = 1'b0; req_addr = mk_addr(pool[5]); req_data = rnd128();
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
      check_val("bp_ignored_rdy", req_rdy, 0);
    end
    req_en = 1'b0;
    n = 0;
    while (!rsp_en && n < 50) begin @(posedge sys_clk); #1; n++; end
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      check_val("bp_rsp_en_held", rsp_en, 1);
      check_val("bp_rsp_data_stable", rsp_data, held);
    end
    rsp_rdy = 1'b1;
    wait_idle();
    check_val("bp_drain_count", n_rsp - base_rsp, 5);

    // Upper address bits alias onto the same line.
    send(1'b0, 27'h7E0AAA8, 128'hAAAABBBB);
    send(1'b1, 27'h000AAA8, '0);
    wait_idle();
    check_val("alias_model", mem_m['h155], 128'hAAAABBBB);

    // Reset two cycles after a read pop, with a write still queued.
    saved_idx = pool[6];
    saved_val = mem_m[saved_idx];
    send(1'b1, mk_addr(pool[7]), '0);
    send(1'b0, mk_addr(saved_idx), rnd128());
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    RST = 1'b1;
    #1;
    check_val("rst_rsp_en", rsp_en, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_req_rdy", req_rdy, 1);
    exp_q.delete();
    n_reads_exp--;
    mem_m[saved_idx] = saved_val;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    RST = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk); #1;
      if (rsp_en) saw = 1'b1;
    end
    check_val("rst_no_rsp", saw, 0);
    check_val("rst_busy_after", busy, 0);
    send(1'b1, mk_addr(saved_idx), '0);
    send(1'b1, 27'h0000AA8, '0);
    wait_idle();

    // Write throughput.
    for (int i = 0; i < 8; i++) begin
      a = mk_addr(pool[i]); d = rnd128();
      req_en = 1'b1; req_cmd = 1'b0; req_addr = a; req_data = d;
      check_val("wr_tput_rdy", req_rdy, 1);
      @(posedge sys_clk); #1;
      model_accept(1'b0, a, d);
    end
    req_en = 1'b0;
    @(posedge sys_clk); #1;
    check_val("wr_tput_busy_t1", busy, 1);
    @(posedge sys_clk); #1;
    check_val("wr_tput_busy_t2", busy, 0);

    // Random mix with random response backpressure.
    pend = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        c = 1'($urandom_range(0, 1));
        a = mk_addr(pool[$urandom_range(0, 7)]);
        d = rnd128();
        req_en = 1'b1; req_cmd = c; req_addr = a; req_data = d;
        pend = 1'b1;
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      rdy_s = req_rdy;
      @(posedge sys_clk); #1;
      if (pend && rdy_s) begin
        model_accept(c, a, d);
        pend = 1'b0;
        req_en = 1'b0;
      end
    end
    req_en = 1'b0;
    rsp_rdy = 1'b1;
    wait_idle();
    check_val("final_exp_empty", exp_q.size(), 0);
    check_val("final_rsp_count", n_rsp, n_reads_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
